// File: rtl/md_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface md_unit_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, cancel, input busy, hi, lo);
   modport slave  (input start, op, a, b, cancel, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at launch and held pending until the latency expires.
module md_unit #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic      clk,
   input logic      reset,
   md_unit_if.slave md
);
   localparam int unsigned W       = WIDTH;
   localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [W-1:0]  hi_q, hi_nx, lo_q, lo_nx;
   logic [W-1:0]  pend_hi, pend_hi_nx, pend_lo, pend_lo_nx;
   logic          pend_wr, pend_wr_nx;
   logic          busy_q, busy_nx;

   // Arithmetic datapath: products and sign-magnitude division
   logic [2*W-1:0] prod_s, prod_u;
   logic           div_sgn, a_neg, b_neg;
   logic [W-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

   assign prod_s = {{W{md.a[W-1]}}, md.a} * {{W{md.b[W-1]}}, md.b};
   assign prod_u = {{W{1'b0}}, md.a} * {{W{1'b0}}, md.b};

   assign div_sgn = (md.op == 3'd2);
   assign a_neg   = div_sgn & md.a[W-1];
   assign b_neg   = div_sgn & md.b[W-1];
   assign a_mag   = a_neg ? (~md.a + W'(1)) : md.a;
   assign b_mag   = b_neg ? (~md.b + W'(1)) : md.b;
   // Zero divisor is steered to 1 only to keep the divider defined; result is dropped
   assign b_safe  = (b_mag == '0) ? W'(1) : b_mag;
   assign q_mag   = a_mag / b_safe;
   assign r_mag   = a_mag % b_safe;
   assign quo     = (a_neg ^ b_neg) ? (~q_mag + W'(1)) : q_mag;
   assign rem     = a_neg ? (~r_mag + W'(1)) : r_mag;

   // State and architectural registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         hi_q    <= hi_nx;
         lo_q    <= lo_nx;
         pend_hi <= pend_hi_nx;
         pend_lo <= pend_lo_nx;
         pend_wr <= pend_wr_nx;
         busy_q  <= busy_nx;
      end
   end

   // Next-state, launch and writeback decisions
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      hi_nx      = hi_q;
      lo_nx      = lo_q;
      pend_hi_nx = pend_hi;
      pend_lo_nx = pend_lo;
      pend_wr_nx = pend_wr;
      busy_nx    = 1'b0;

      case (state)
         IDLE: begin
            if (md.start && !md.cancel) begin
               case (md.op)
                  3'd0, 3'd1: begin
                     {pend_hi_nx, pend_lo_nx} = (md.op == 3'd0) ? prod_s : prod_u;
                     pend_wr_nx = 1'b1;
                     cnt_nx     = CW'(MULT_CYCLES);
                     state_nx   = RUN;
                  end
                  3'd2, 3'd3: begin
                     pend_hi_nx = rem;
                     pend_lo_nx = quo;
                     pend_wr_nx = (md.b != '0);
                     cnt_nx     = CW'(DIV_CYCLES);
                     state_nx   = RUN;
                  end
                  3'd4:    hi_nx = md.a;
                  3'd5:    lo_nx = md.a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (md.cancel) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == CW'(1)) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               if (pend_wr) begin
                  hi_nx = pend_hi;
                  lo_nx = pend_lo;
               end
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase

      busy_nx = (state_nx == RUN);
   end

   assign md.busy = busy_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed HI/LO results, busy timing, cancel and reset.
module tb_md_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   md_unit_if #(.WIDTH(32)) io ();

   md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (io.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_hl(input string tag, input logic [31:0] h, input logic [31:0] l);
      check({tag, ".hi"}, io.hi, h);
      check({tag, ".lo"}, io.lo, l);
   endtask

   // Launch an op, expect busy for n sampled cycles, then busy low
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int n, input string tag);
      io.start = 1'b1; io.op = o; io.a = x; io.b = y;
      @(negedge clk);
      io.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s.busy%0d", tag, i + 1), {31'd0, io.busy}, 32'd1);
         @(negedge clk);
      end
      check({tag, ".done"}, {31'd0, io.busy}, 32'd0);
   endtask

   task automatic move_op(input logic [2:0] o, input logic [31:0] x, input string tag);
      io.start = 1'b1; io.op = o; io.a = x; io.b = '0;
      @(negedge clk);
      io.start = 1'b0;
      check({tag, ".busy"}, {31'd0, io.busy}, 32'd0);
   endtask

   initial begin
      io.start = 1'b0; io.op = 3'd0; io.a = '0; io.b = '0; io.cancel = 1'b0;

      repeat (3) @(negedge clk);
      check("rst.busy", {31'd0, io.busy}, 32'd0);
      check_hl("rst", 32'h0, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      run_op(3'd0, 32'hFFFF_FFFD, 32'h7, 5, "mult_neg");
      check_hl("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 5, "multu");
      check_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);

      run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 5, "mult_m1");
      check_hl("mult_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 10, "div_neg");
      check_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      run_op(3'd3, 32'h7, 32'h0, 10, "divu_z");
      check_hl("divu_z", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      run_op(3'd3, 32'd100, 32'd7, 10, "divu");
      check_hl("divu", 32'd2, 32'd14);

      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
      check_hl("div_ovf", 32'h0, 32'h8000_0000);

      move_op(3'd4, 32'h1234, "mthi");
      check_hl("mthi", 32'h1234, 32'h8000_0000);
      move_op(3'd5, 32'h5678, "mtlo");
      check_hl("mtlo", 32'h1234, 32'h5678);

      move_op(3'd6, 32'hAAAA_AAAA, "nop6");
      check_hl("nop6", 32'h1234, 32'h5678);

      io.cancel = 1'b1;
      move_op(3'd4, 32'hDEAD_BEEF, "cancel_idle");
      io.cancel = 1'b0;
      check_hl("cancel_idle", 32'h1234, 32'h5678);

      // Start while busy is ignored; mult lands on time
      io.start = 1'b1; io.op = 3'd0; io.a = 32'd3; io.b = 32'd5;
      @(negedge clk);
      io.start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("ign.busy%0d", i), {31'd0, io.busy}, 32'd1);
         io.start = (i == 2); io.op = 3'd3; io.a = 32'd100; io.b = 32'd3;
         if (i == 4) begin io.start = 1'b1; io.op = 3'd4; io.a = 32'h9999; end
         @(negedge clk);
         io.start = 1'b0;
      end
      check("ign.done", {31'd0, io.busy}, 32'd0);
      check_hl("ign", 32'h0, 32'd15);

      // Cancel at busy cycle 3
      io.start = 1'b1; io.op = 3'd0; io.a = 32'd2; io.b = 32'd2;
      @(negedge clk);
      io.start = 1'b0;
      repeat (2) @(negedge clk);
      check("cxl.busy3", {31'd0, io.busy}, 32'd1);
      io.cancel = 1'b1;
      @(negedge clk);
      io.cancel = 1'b0;
      check("cxl.busy", {31'd0, io.busy}, 32'd0);
      repeat (6) @(negedge clk);
      check_hl("cxl", 32'h0, 32'd15);

      // Cancel in the final busy cycle still suppresses writeback
      io.start = 1'b1; io.op = 3'd1; io.a = 32'd9; io.b = 32'd9;
      @(negedge clk);
      io.start = 1'b0;
      repeat (4) @(negedge clk);
      check("cxl_last.busy5", {31'd0, io.busy}, 32'd1);
      io.cancel = 1'b1;
      @(negedge clk);
      io.cancel = 1'b0;
      check("cxl_last.busy", {31'd0, io.busy}, 32'd0);
      check_hl("cxl_last", 32'h0, 32'd15);

      // Async reset mid-divide
      move_op(3'd4, 32'hABCD, "pre_rst");
      io.start = 1'b1; io.op = 3'd2; io.a = 32'd100; io.b = 32'd7;
      @(negedge clk);
      io.start = 1'b0;
      repeat (3) @(negedge clk);
      check("arst.busy4", {31'd0, io.busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("arst.busy", {31'd0, io.busy}, 32'd0);
      check_hl("arst", 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_hl("arst_hold", 32'h0, 32'h0);

      run_op(3'd0, 32'd6, 32'd7, 5, "post_rst");
      check_hl("post_rst", 32'h0, 32'd42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
